// File: rtl/servant_loader_pkg.sv
// servant_loader_pkg
// Shared definitions for the servant RAM boot loader.
//   load_state_t : loader FSM states (header low byte, header high byte,
//                  data byte collection, RAM write cycle, terminal done)
//   HDR_BYTES    : length of the little-endian word-count header
//   WORD_BYTES   : bytes packed into one RAM word
//   SEL_ALL      : byte-select value for full-word loader writes
package servant_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } load_state_t;

    localparam int         HDR_BYTES  = 2;
    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] SEL_ALL    = 4'hF;

endpackage

// File: rtl/servant_wb_mux.sv
// servant_wb_mux
// Purely combinational owner-select for the RAM Wishbone slave port.
// Ports:
//   sel_cpu          : 1 = CPU owns the RAM port, 0 = loader owns it
//   cpu_*            : CPU master request (adr/dat/sel/we/cyc)
//   ldr_*            : loader master request (adr/dat/sel/we/cyc)
//   ram_adr..ram_cyc : request presented to the RAM
//   ram_rdt, ram_ack : RAM response
//   cpu_rdt, cpu_ack : response returned to the CPU (ack gated while loading)
module servant_wb_mux #(
    parameter int aw = 8
) (
    input  logic          sel_cpu,
    input  logic [aw-3:0] cpu_adr,
    input  logic [31:0]   cpu_dat,
    input  logic [3:0]    cpu_sel,
    input  logic          cpu_we,
    input  logic          cpu_cyc,
    input  logic [aw-3:0] ldr_adr,
    input  logic [31:0]   ldr_dat,
    input  logic [3:0]    ldr_sel,
    input  logic          ldr_we,
    input  logic          ldr_cyc,
    input  logic [31:0]   ram_rdt,
    input  logic          ram_ack,
    output logic [aw-3:0] ram_adr,
    output logic [31:0]   ram_dat,
    output logic [3:0]    ram_sel,
    output logic          ram_we,
    output logic          ram_cyc,
    output logic [31:0]   cpu_rdt,
    output logic          cpu_ack
);

    always_comb begin
        ram_adr = ldr_adr;
        ram_dat = ldr_dat;
        ram_sel = ldr_sel;
        ram_we  = ldr_we;
        ram_cyc = ldr_cyc;
        cpu_ack = 1'b0;
        if (sel_cpu) begin
            ram_adr = cpu_adr;
            ram_dat = cpu_dat;
            ram_sel = cpu_sel;
            ram_we  = cpu_we;
            ram_cyc = cpu_cyc;
            cpu_ack = ram_ack;
        end
    end

    // Read data needs no steering: the CPU is held in reset while loading.
    assign cpu_rdt = ram_rdt;

endmodule

// File: rtl/servant_ram_loader.sv
// servant_ram_loader
// Boot-time loader: receives a byte stream (16-bit LE word count, then that
// many LE 32-bit words), writes the words into the servant RAM, keeps the CPU
// in reset while doing so, then hands the RAM port to the CPU.
// Ports:
//   i_wb_clk, i_wb_rst_n       : clock, async active-low reset
//   i_load_en                  : strap, 0 = skip loading entirely
//   i_byte, i_byte_valid,
//   o_byte_ready               : byte stream handshake
//   o_cpu_rst, o_done          : CPU reset (active high), load finished
//   i_cpu_wb_*, o_cpu_wb_*     : CPU Wishbone master side
//   o_ram_wb_*, i_ram_wb_*     : RAM Wishbone slave side
// Handshake: a byte moves on a rising edge where i_byte_valid and
// o_byte_ready are both high; o_byte_ready never looks at i_byte_valid.
module servant_ram_loader
    import servant_loader_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst_n,
    input  logic          i_load_en,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    output logic          o_cpu_rst,
    output logic          o_done,
    input  logic [aw-3:0] i_cpu_wb_adr,
    input  logic [31:0]   i_cpu_wb_dat,
    input  logic [3:0]    i_cpu_wb_sel,
    input  logic          i_cpu_wb_we,
    input  logic          i_cpu_wb_cyc,
    output logic [31:0]   o_cpu_wb_rdt,
    output logic          o_cpu_wb_ack,
    output logic [aw-3:0] o_ram_wb_adr,
    output logic [31:0]   o_ram_wb_dat,
    output logic [3:0]    o_ram_wb_sel,
    output logic          o_ram_wb_we,
    output logic          o_ram_wb_cyc,
    input  logic [31:0]   i_ram_wb_rdt,
    input  logic          i_ram_wb_ack
);

    localparam logic [15:0] RAM_WORDS = 16'(depth / 4);
    localparam logic [1:0]  LAST_LANE = 2'(WORD_BYTES - 1);

    load_state_t state, state_next;

    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  lane;
    logic [31:0] word;
    logic        armed;
    logic        cpu_rst_q;
    logic        done_q;

    logic        byte_ready;
    logic        accept;
    logic        ldr_cyc;
    logic        word_done;
    logic        word_fits;
    logic        last_word;

    // Words past the end of the RAM are consumed but never written, so the
    // stream stays aligned and the address never wraps onto low memory.
    assign word_fits = (word_idx < RAM_WORDS);
    assign last_word = (word_idx == (n_words - 16'd1));

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state <= ST_HDR0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        ldr_cyc    = 1'b0;
        accept     = 1'b0;
        word_done  = 1'b0;
        case (state)
            ST_HDR0: begin
                if (!i_load_en) begin
                    state_next = ST_DONE;
                end else begin
                    // Held low through reset and its first clock afterwards.
                    byte_ready = armed;
                    accept     = i_byte_valid & byte_ready;
                    if (accept) begin
                        state_next = ST_HDR1;
                    end
                end
            end
            ST_HDR1: begin
                byte_ready = 1'b1;
                accept     = i_byte_valid;
                if (accept) begin
                    if ({i_byte, n_words[7:0]} == 16'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                byte_ready = 1'b1;
                accept     = i_byte_valid;
                word_done  = accept & (lane == LAST_LANE);
                if (word_done) begin
                    if (word_fits) begin
                        state_next = ST_WRITE;
                    end else if (last_word) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                ldr_cyc = 1'b1;
                if (i_ram_wb_ack) begin
                    state_next = last_word ? ST_DONE : ST_DATA;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_HDR0;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            n_words   <= 16'd0;
            word_idx  <= 16'd0;
            lane      <= 2'd0;
            word      <= 32'd0;
            armed     <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            armed     <= 1'b1;
            cpu_rst_q <= (state_next != ST_DONE);
            done_q    <= (state_next == ST_DONE);
            if (accept && state == ST_HDR0) begin
                n_words[7:0] <= i_byte;
            end
            if (accept && state == ST_HDR1) begin
                n_words[15:8] <= i_byte;
            end
            if (accept && state == ST_DATA) begin
                // Shift right so the first byte of a word ends up in [7:0].
                word <= {i_byte, word[31:8]};
                lane <= lane + 2'd1;
            end
            if (word_done && !word_fits) begin
                word_idx <= word_idx + 16'd1;
            end
            if (state == ST_WRITE && i_ram_wb_ack) begin
                word_idx <= word_idx + 16'd1;
            end
        end
    end

    assign o_byte_ready = byte_ready;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_done       = done_q;

    servant_wb_mux #(
        .aw (aw)
    ) u_mux (
        .sel_cpu (done_q),
        .cpu_adr (i_cpu_wb_adr),
        .cpu_dat (i_cpu_wb_dat),
        .cpu_sel (i_cpu_wb_sel),
        .cpu_we  (i_cpu_wb_we),
        .cpu_cyc (i_cpu_wb_cyc),
        .ldr_adr (word_idx[aw-3:0]),
        .ldr_dat (word),
        .ldr_sel (ldr_cyc ? SEL_ALL : 4'h0),
        .ldr_we  (ldr_cyc),
        .ldr_cyc (ldr_cyc),
        .ram_rdt (i_ram_wb_rdt),
        .ram_ack (i_ram_wb_ack),
        .ram_adr (o_ram_wb_adr),
        .ram_dat (o_ram_wb_dat),
        .ram_sel (o_ram_wb_sel),
        .ram_we  (o_ram_wb_we),
        .ram_cyc (o_ram_wb_cyc),
        .cpu_rdt (o_cpu_wb_rdt),
        .cpu_ack (o_cpu_wb_ack)
    );

endmodule

// File: tb/tb_servant_ram_loader.sv
// tb_servant_ram_loader
// Directed bench for servant_ram_loader with a servant-style RAM model
// (registered read data, one-cycle ack) and a stream-level expectation model.
module tb_servant_ram_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int WORDS = DEPTH / 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          rst_n;
    logic          i_load_en;
    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic          o_byte_ready;
    logic          o_cpu_rst;
    logic          o_done;
    logic [AW-3:0] i_cpu_wb_adr;
    logic [31:0]   i_cpu_wb_dat;
    logic [3:0]    i_cpu_wb_sel;
    logic          i_cpu_wb_we;
    logic          i_cpu_wb_cyc;
    logic [31:0]   o_cpu_wb_rdt;
    logic          o_cpu_wb_ack;
    logic [AW-3:0] o_ram_wb_adr;
    logic [31:0]   o_ram_wb_dat;
    logic [3:0]    o_ram_wb_sel;
    logic          o_ram_wb_we;
    logic          o_ram_wb_cyc;
    logic [31:0]   ram_rdt;
    logic          ram_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    servant_ram_loader #(
        .depth (DEPTH)
    ) dut (
        .i_wb_clk     (clk),
        .i_wb_rst_n   (rst_n),
        .i_load_en    (i_load_en),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_cpu_rst    (o_cpu_rst),
        .o_done       (o_done),
        .i_cpu_wb_adr (i_cpu_wb_adr),
        .i_cpu_wb_dat (i_cpu_wb_dat),
        .i_cpu_wb_sel (i_cpu_wb_sel),
        .i_cpu_wb_we  (i_cpu_wb_we),
        .i_cpu_wb_cyc (i_cpu_wb_cyc),
        .o_cpu_wb_rdt (o_cpu_wb_rdt),
        .o_cpu_wb_ack (o_cpu_wb_ack),
        .o_ram_wb_adr (o_ram_wb_adr),
        .o_ram_wb_dat (o_ram_wb_dat),
        .o_ram_wb_sel (o_ram_wb_sel),
        .o_ram_wb_we  (o_ram_wb_we),
        .o_ram_wb_cyc (o_ram_wb_cyc),
        .i_ram_wb_rdt (ram_rdt),
        .i_ram_wb_ack (ram_ack)
    );

    // ---------------- RAM model ----------------
    logic [31:0] mem [WORDS];
    logic        mem_fill;
    logic [31:0] fill_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram_ack <= 1'b0;
        else        ram_ack <= o_ram_wb_cyc & ~ram_ack;
    end

    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= fill_val;
        end else if (o_ram_wb_cyc && o_ram_wb_we && !ram_ack) begin
            for (int b = 0; b < 4; b++)
                if (o_ram_wb_sel[b]) mem[o_ram_wb_adr][b*8 +: 8] <= o_ram_wb_dat[b*8 +: 8];
        end
        ram_rdt <= mem[o_ram_wb_adr];
    end

    // ---------------- model / scoreboard ----------------
    logic [7:0]  stream [$];
    logic [37:0] exp_q [$];
    logic [31:0] exp_mem [WORDS];
    int          writes_seen;
    int          checks;
    int          failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected RAM writes follow straight from the stream layout.
    task automatic build_model();
        int          n;
        logic [31:0] w;
        n = int'(stream[0]) | (int'(stream[1]) << 8);
        for (int i = 0; i < n; i++) begin
            w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
            if (i < WORDS) begin
                exp_q.push_back({6'(i), w});
                exp_mem[i] = w;
            end
        end
    endtask

    // One cycle: advance to the falling edge and check the outputs there.
    task automatic tick();
        logic [37:0] exp_w;
        @(negedge clk);
        if (rst_n) begin
            if (!o_done) begin
                chk("cpu_ack_while_loading", o_cpu_wb_ack, 0);
                chk("cpu_rst_while_loading", o_cpu_rst, 1);
                if (o_ram_wb_cyc) begin
                    chk("ready_during_write", o_byte_ready, 0);
                    chk("write_we", o_ram_wb_we, 1);
                    chk("write_sel", o_ram_wb_sel, 4'hF);
                    if (ram_ack) begin
                        writes_seen++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write", {o_ram_wb_adr, o_ram_wb_dat}, 0);
                        end else begin
                            exp_w = exp_q.pop_front();
                            chk("ram_write", {o_ram_wb_adr, o_ram_wb_dat}, exp_w);
                        end
                    end
                end
            end else begin
                chk("cpu_rst_after_done", o_cpu_rst, 0);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (o_byte_ready) begin
                tick();
                i_byte_valid = 1'b0;
                return;
            end
            tick();
        end
        i_byte_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL send_byte_timeout actual=not_accepted required=accepted");
    endtask

    task automatic send_range(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
            send_byte(stream[i]);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (o_done) break;
            tick();
        end
        chk("done_reached", o_done, 1);
    endtask

    task automatic cpu_read(input logic [AW-3:0] adr, input logic [31:0] req, input string name);
        i_cpu_wb_adr = adr;
        i_cpu_wb_we  = 1'b0;
        i_cpu_wb_sel = 4'hF;
        i_cpu_wb_cyc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_cpu_wb_ack) begin
                chk(name, o_cpu_wb_rdt, req);
                i_cpu_wb_cyc = 1'b0;
                return;
            end
        end
        i_cpu_wb_cyc = 1'b0;
        checks++;
        failures++;
        $display("FAIL %s_ack_timeout actual=no_ack required=ack", name);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cpu_rst"}, o_cpu_rst, 1);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_ready"}, o_byte_ready, 0);
        chk({tag, "_ram_cyc"}, o_ram_wb_cyc, 0);
        chk({tag, "_ram_we"}, o_ram_wb_we, 0);
        chk({tag, "_ram_sel"}, o_ram_wb_sel, 0);
        chk({tag, "_ram_adr"}, o_ram_wb_adr, 0);
        chk({tag, "_ram_dat"}, o_ram_wb_dat, 0);
        chk({tag, "_cpu_ack"}, o_cpu_wb_ack, 0);
    endtask

    task automatic do_reset(input logic fill, input logic [31:0] val);
        rst_n        = 1'b0;
        i_byte_valid = 1'b0;
        i_cpu_wb_cyc = 1'b0;
        mem_fill     = fill;
        fill_val     = val;
        repeat (3) tick();
        mem_fill = 1'b0;
        check_reset_values("reset");
        if (fill) for (int i = 0; i < WORDS; i++) exp_mem[i] = val;
        exp_q.delete();
        stream.delete();
        writes_seen = 0;
        rst_n = 1'b1;
    endtask

    task automatic check_image(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk(name, bad, 0);
    endtask

    // ---------------- tests ----------------
    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        i_load_en    = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_cpu_wb_adr = '0;
        i_cpu_wb_dat = 32'h0;
        i_cpu_wb_sel = 4'h0;
        i_cpu_wb_we  = 1'b0;
        i_cpu_wb_cyc = 1'b0;
        mem_fill     = 1'b0;
        fill_val     = 32'h0;

        // Loading skipped: done one edge after release, CPU reads pass through.
        i_load_en = 1'b0;
        do_reset(1'b1, 32'h5A5A_5A5A);
        chk("skip_done_before_edge", o_done, 0);
        tick();
        chk("skip_done_after_1_edge", o_done, 1);
        chk("skip_cpu_rst_after_1_edge", o_cpu_rst, 0);
        chk("skip_no_writes", writes_seen, 0);
        cpu_read(6'd0, 32'h5A5A_5A5A, "skip_cpu_read0");

        // Two-word load.
        i_load_en = 1'b1;
        do_reset(1'b1, 32'h0);
        stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        build_model();
        send_range(0, stream.size() - 1, 0);
        wait_done(20);
        chk("two_word_writes", writes_seen, 2);
        chk("two_word_queue_empty", exp_q.size(), 0);
        chk("two_word_mem0", mem[0], 32'h1234_5678);
        chk("two_word_mem1", mem[1], 32'hDEAD_BEEF);
        check_image("two_word_image");
        cpu_read(6'd1, 32'hDEAD_BEEF, "two_word_cpu_read1");

        // Empty program.
        do_reset(1'b1, 32'h0);
        stream = '{8'h00, 8'h00};
        send_range(0, 1, 0);
        chk("empty_done_after_header", o_done, 1);
        tick();
        chk("empty_no_writes", writes_seen, 0);

        // 65 words into a 64-word RAM: the last word is consumed, never written.
        do_reset(1'b1, 32'hFFFF_FFFF);
        stream.push_back(8'd65);
        stream.push_back(8'd0);
        for (int i = 0; i < 65; i++) begin
            stream.push_back(8'(i));
            stream.push_back(8'h00);
            stream.push_back(8'hDE);
            stream.push_back(8'hC0);
        end
        build_model();
        send_range(0, 260, 0);
        chk("overflow_not_done_before_last", o_done, 0);
        send_range(261, 261, 0);
        chk("overflow_done_after_262", o_done, 1);
        chk("overflow_writes", writes_seen, 64);
        chk("overflow_mem0_kept", mem[0], 32'hC0DE_0000);
        chk("overflow_mem63", mem[63], 32'hC0DE_003F);
        check_image("overflow_image");

        // Random valid gaps.
        do_reset(1'b1, 32'h0);
        stream = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                   8'hCC, 8'hBB, 8'hAA, 8'h99};
        build_model();
        send_range(0, stream.size() - 1, 3);
        wait_done(30);
        chk("gaps_writes", writes_seen, 3);
        chk("gaps_mem2", mem[2], 32'h99AA_BBCC);
        check_image("gaps_image");

        // Reset in the middle of a load, then a fresh stream.
        do_reset(1'b1, 32'h0);
        stream = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
        send_range(0, 4, 0);
        chk("midreset_partial_word", o_ram_wb_dat, 32'h0302_0100);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset_immediate");
        do_reset(1'b0, 32'h0);
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build_model();
        send_range(0, stream.size() - 1, 0);
        wait_done(20);
        chk("midreset_writes", writes_seen, 1);
        chk("midreset_mem0", mem[0], 32'hDDCC_BBAA);
        check_image("midreset_image");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servant_ram_loader.md
# servant_ram_loader

Boot-time program loader between the CPU's Wishbone data/instruction port and the servant RAM. After reset it takes a little-endian byte stream from an upstream byte source (UART/SPI receiver) through a valid/ready handshake, packs it into 32-bit words, and writes them into RAM through the RAM's Wishbone slave port. While loading, it holds the CPU in reset and owns the RAM port. Afterwards it hands the RAM port to the CPU combinationally and releases CPU reset.

## Interface
- `depth`, 256: RAM size in bytes; must match the RAM.
- `aw`, `$clog2(depth)`: byte-address width.
- `i_wb_clk`  in  1  sole clock.
- `i_wb_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_load_en`  in  1  static strap; 0 = skip loading.
- `i_byte`  in  8  stream byte.
- `i_byte_valid`  in  1  upstream has a byte.
- `o_byte_ready`  out  1  loader accepts a byte this cycle.
- `o_cpu_rst`  out  1  active-high CPU reset.
- `o_done`  out  1  load finished; RAM port handed to CPU.
- `i_cpu_wb_adr`  in  aw-2  CPU word address [aw-1:2].
- `i_cpu_wb_dat`  in  32  CPU write data.
- `i_cpu_wb_sel`  in  4  CPU byte selects.
- `i_cpu_wb_we`  in  1  CPU write enable.
- `i_cpu_wb_cyc`  in  1  CPU cycle.
- `o_cpu_wb_rdt`  out  32  read data to CPU.
- `o_cpu_wb_ack`  out  1  ack to CPU.
- `o_ram_wb_adr`, `o_ram_wb_dat`, `o_ram_wb_sel`, `o_ram_wb_we`, `o_ram_wb_cyc`  out  aw-2/32/4/1/1  RAM master port.
- `i_ram_wb_rdt`  in  32  RAM read data.
- `i_ram_wb_ack`  in  1  RAM ack.

## Operation
- Stream format: 2-byte word count N (LSB first), then N words of 4 bytes each. The first byte of each word goes to [7:0].
- The FSM has five states: HDR0, HDR1, DATA, WRITE and DONE. Reset state is HDR0.
- HDR0:
  - If `i_load_en`=0, go to DONE next cycle. `o_byte_ready`=0.
  - Otherwise `o_byte_ready`=1. On accept, latch N[7:0] and go to HDR1.
- HDR1:
  - On accept, latch N[15:8].
  - If N=0, go to DONE. Otherwise go to DATA.
- DATA:
  - `o_byte_ready`=1.
  - A 2-bit lane counter shifts bytes into a 32-bit word register.
  - On the 4th byte:
    - If word index < depth/4, go to WRITE.
    - Otherwise the word is dropped (no bus cycle), the index is incremented and the FSM stays in DATA. This keeps the stream in sync.
    - After the last word (index = N-1), go to DONE instead.
- WRITE:
  - `o_byte_ready`=0.
  - Drive `o_ram_wb_cyc`=1, `we`=1, `sel`=4'hF, `adr`=word index, `dat`=word register.
  - Hold until `i_ram_wb_ack`. The cycle after ack, deassert cyc and increment the index.
  - Next state is DATA, or DONE if this was word N-1.
- DONE: terminal. Leaves only on reset.
- Byte transfer happens when `i_byte_valid` and `o_byte_ready` are both high on a rising edge. `o_byte_ready` does not depend on `i_byte_valid`.
- Counters: N is 16 bits; word index is 16 bits with no wrap (N ≤ 65535).
- Bus mux (combinational on the state):
  - State ≠ DONE: RAM port is driven by loader registers. `o_cpu_wb_ack`=0; `o_cpu_wb_rdt`=`i_ram_wb_rdt`.
  - State = DONE: RAM port outputs equal the CPU inputs, and `o_cpu_wb_ack`=`i_ram_wb_ack`.

## Timing
- Reset values:
  - State HDR0, `o_cpu_rst`=1, `o_done`=0, `o_byte_ready`=0 (until the first cycle after release).
  - Loader `cyc`/`we`=0, `adr`/`dat`=0, `sel`=0.
- `o_cpu_rst` and `o_done` are registered. They change on the same edge that enters DONE.
- Per stored word the minimum is 4 accept cycles + 2 WRITE cycles (cyc, then ack against the RAM's 1-cycle ack).
- A reset assertion mid-load immediately forces the reset values; any partial RAM contents stay as written.
- `i_load_en`=0: DONE is reached on the 1st edge after reset release.

## Structure
- `servant_loader_pkg` holds:
  - the state enum;
  - `HDR_BYTES`=2 and `WORD_BYTES`=4;
  - the `sel` constant 4'hF.
- Sub-module `servant_wb_mux` is the purely combinational CPU/loader port mux, selected by `o_done`. The FSM, lane counter and word register live at top level.

## Test plan
- `i_load_en`=0: `o_cpu_rst` falls and `o_done` rises 1 edge after reset release; no RAM cyc; a CPU read of word 0 passes through with ack.
- Stream 02 00 78 56 34 12 EF BE AD DE:
  - exactly two RAM writes, sel F: adr 0 = 0x12345678, adr 1 = 0xDEADBEEF;
  - then `o_done`=1, and a CPU read of adr 1 returns 0xDEADBEEF.
- Stream 00 00: DONE right after the header byte; zero RAM cycles.
- depth=256, N=65: 64 writes, word 65 consumed but not written, RAM word 0 unchanged after the final write; DONE after 262 bytes.
- Random `i_byte_valid` gaps with N=3:
  - `o_byte_ready` is low for every WRITE cycle;
  - no byte is lost or duplicated, and the RAM image matches the stream;
  - CPU ack stays 0 throughout loading.
- `i_wb_rst_n` pulsed low after 5 bytes of an N=2 stream:
  - outputs return to reset values immediately;
  - a fresh stream 01 00 AA BB CC DD then writes 0xDDCCBBAA to adr 0 and completes.
